regfile_dbg_port: RTL and testbench

Debug access controller for the 32 x 32-bit general-purpose register file. On command, it can dump a contiguous range of registers, wrapping at 31, onto a valid/ready output stream through one register-file read port. It can also load a range from a valid/ready input stream through the register-file write port. It sits between the debug/host interface and the register file, and borrows a read port (`re`/`raddr`/`rdata`) and the write port (`we`/`waddr`/`wdata`) while the core is halted.

---
 rtl/regfile_dbg_port.sv | 118 +++++++++++
 tb/tb_regfile_dbg_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_port.sv
// Debug access controller for the register file: dumps a register range to an
// output stream or loads a range from an input stream, with wrap at the top.
module regfile_dbg_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_count,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [DATA_W-1:0] din_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUMP,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remain;
    logic              more;

    assign more      = (remain != '0);
    assign cmd_ready = !rst && (state == S_IDLE);
    // A stalled output word blocks the next read so no data is dropped.
    assign rf_re     = !rst && (state == S_DUMP) && more &&
                       (!dout_valid || dout_ready);
    assign rf_raddr  = addr;
    assign din_ready = !rst && (state == S_LOAD) && more;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            remain     <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_last  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr   <= cmd_base;
                        remain <= (cmd_count == '0) ? FULL
                                                    : {1'b0, cmd_count};
                        busy   <= 1'b1;
                        state  <= cmd_load ? S_LOAD : S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (rf_re) begin
                        dout_valid <= 1'b1;
                        dout_data  <= rf_rdata;
                        dout_last  <= (remain == ONE);
                        addr       <= addr + A_ONE;
                        remain     <= remain - ONE;
                    end else if (dout_valid && dout_ready) begin
                        dout_valid <= 1'b0;
                        if (dout_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (din_ready && din_valid) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= addr;
                        rf_wdata <= din_data;
                        addr     <= addr + A_ONE;
                        remain   <= remain - ONE;
                    end else if (!more) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Scoreboard bench for regfile_dbg_port with a register-file model and a
// reference array of register contents.
module tb_regfile_dbg_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_load = 1'b0;
    logic [4:0]  cmd_base = '0;
    logic [4:0]  cmd_count = '0;
    logic        rf_re;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [31:0] dout_data;
    logic        dout_last;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] din_data = '0;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    regfile_dbg_port #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_base(cmd_base), .cmd_count(cmd_count),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_last(dout_last),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .busy(busy), .done(done)
    );

    // Register file seen by the DUT; register 0 is hardwired to zero.
    logic [31:0] regs [32];
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];
    always @(posedge clk)
        if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;

    // Reference contents, updated when a load word is handed over.
    logic [31:0] ref_rf [32];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          last;
    } exp_t;

    exp_t       wq[$];
    exp_t       dq[$];
    logic [4:0] aq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_done = -1;
    int done_cnt = 0;
    bit prev_done = 0;
    int rmode = 0;
    int rk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected/missing event, expected none", name);
    endtask

    // Consumer ready: 0 = always, 1 = 1,0,0 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        rk++;
        case (rmode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = (rk % 3 == 0);
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares every DUT output event against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_done = -1;
            prev_done = 0;
        end else begin
            if (rf_re) begin
                if (aq.size() == 0) fail("extra_read");
                else check("read_addr", 64'(rf_raddr), 64'(aq.pop_front()));
            end
            if (rf_we) begin
                if (wq.size() == 0) fail("extra_write");
                else begin
                    e = wq.pop_front();
                    check("write_addr", 64'(rf_waddr), 64'(e.a));
                    check("write_data", 64'(rf_wdata), 64'(e.d));
                    if (e.last) exp_done = cyc + 1;
                end
            end
            if (dout_valid) begin
                if (dq.size() == 0) fail("extra_dout");
                else begin
                    check("dout_data", 64'(dout_data), 64'(dq[0].d));
                    check("dout_last", 64'(dout_last), 64'(dq[0].last));
                    if (dout_ready) begin
                        e = dq.pop_front();
                        if (e.last) exp_done = cyc + 1;
                    end
                end
            end
            if (prev_done) begin
                check("ready_after_done", 64'(cmd_ready), 64'd1);
                check("idle_after_done", 64'(busy), 64'd0);
            end
            if (done) begin
                check("done_time", 64'(cyc), 64'(exp_done));
                check("busy_at_done", 64'(busy), 64'd1);
                exp_done = -1;
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic send_cmd(bit load, int base, int cnt);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) fail("cmd_ready_timeout");
        cmd_valid = 1'b1;
        cmd_load  = load;
        cmd_base  = 5'(base);
        cmd_count = 5'(cnt);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(string name);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (done_cnt == start) fail(name);
    endtask

    task automatic do_dump(int base, int cnt, int mode);
        logic [4:0] a;
        rmode = mode;
        for (int i = 0; i < cnt; i++) begin
            a = 5'((base + i) % 32);
            aq.push_back(a);
            dq.push_back('{a, ref_rf[a], (i == cnt - 1)});
        end
        send_cmd(1'b0, base, cnt);
        wait_done("dump_done_timeout");
    endtask

    task automatic do_load(int base, int cnt, input logic [31:0] w[$],
                           int gap, int stop);
        logic [4:0] a;
        int n;
        send_cmd(1'b1, base, cnt);
        for (int i = 0; i < stop; i++) begin
            a = 5'((base + i) % 32);
            din_valid = 1'b0;
            if (i > 0) repeat (gap) begin @(posedge clk); #1; end
            din_valid = 1'b1;
            din_data  = w[i];
            n = 0;
            while (!din_ready && n < 100) begin
                @(posedge clk); #1; n++;
            end
            if (!din_ready) fail("din_ready_timeout");
            @(posedge clk); #1;
            wq.push_back('{a, w[i], (i == cnt - 1)});
            if (a != 5'd0) ref_rf[a] = w[i];
        end
        din_valid = 1'b0;
        if (stop == cnt) wait_done("load_done_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        int base, cnt;
        foreach (ref_rf[i]) ref_rf[i] = 32'd0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rf_re", 64'(rf_re), 64'd0);
        check("rst_din_ready", 64'(din_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outs",
              {rf_we, rf_waddr, rf_wdata, dout_valid, dout_data,
               dout_last, done, busy},
              64'd0);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Fill all 32 registers (count 0 = 32), including a discarded r0 write.
        w = {};
        for (int i = 0; i < 32; i++) w.push_back($urandom);
        w[1] = 32'h11; w[2] = 32'h22; w[3] = 32'h33;
        do_load(0, 32, w, 0, 32);

        do_dump(0, 4, 0);
        do_dump(30, 3, 1);

        w = {32'hDEADBEEF, 32'h12345678};
        do_load(5, 2, w, 2, 2);
        do_dump(5, 2, 0);

        do_dump($urandom_range(0, 31), 32, 2);

        for (int k = 0; k < 8; k++) begin
            base = $urandom_range(0, 31);
            cnt  = $urandom_range(1, 32);
            if ($urandom_range(0, 1) == 1) begin
                w = {};
                for (int i = 0; i < cnt; i++) w.push_back($urandom);
                do_load(base, cnt, w, $urandom_range(0, 2), cnt);
            end else begin
                do_dump(base, cnt, $urandom_range(0, 2));
            end
        end

        // Abandon a load of 4 after 2 words.
        w = {32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
        do_load(9, 4, w, 0, 2);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_wq_empty", 64'(wq.size()), 64'd0);
        repeat (5) begin @(posedge clk); #1; end
        do_dump(0, 32, 2);

        repeat (5) begin @(posedge clk); #1; end
        check("dq_empty", 64'(dq.size()), 64'd0);
        check("aq_empty", 64'(aq.size()), 64'd0);
        check("wq_empty", 64'(wq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
